// File: rtl/accum_pkg.sv
// Shared types and helpers for the accum_sched leaky-accumulator scheduler.
package accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_REPORT
    } sched_state_e;

    // Width of a per-channel count register; never narrower than one bit.
    function automatic int count_width(input int threshold);
        return (threshold > 1) ? $clog2(threshold) : 1;
    endfunction

endpackage

// File: rtl/accum_sched_if.sv
// Step/report handshake bundle for accum_sched; master is the host, slave is the scheduler.
interface accum_sched_if #(
    parameter int N_CH = 8
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            prop_in;
    logic [N_CH-1:0] inc_in;
    logic            busy_out;
    logic            step_done_out;
    logic            win_valid_out;
    logic            win_ready_in;
    logic [IW-1:0]   win_idx_out;
    logic [N_CH-1:0] trig_mask_out;
    logic            overrun_out;

    modport master (
        output prop_in, inc_in, win_ready_in,
        input  busy_out, step_done_out, win_valid_out, win_idx_out,
               trig_mask_out, overrun_out
    );

    modport slave (
        input  prop_in, inc_in, win_ready_in,
        output busy_out, step_done_out, win_valid_out, win_idx_out,
               trig_mask_out, overrun_out
    );

endinterface

// File: rtl/accum_lane_update.sv
// Combinational next-count and trigger for one accumulator channel.
module accum_lane_update #(
    parameter int THRESHOLD = 192,
    parameter int CW        = 8
) (
    input  logic [CW-1:0] count,
    input  logic          inc,
    input  logic          leak,
    output logic [CW-1:0] next_count,
    output logic          trig
);
    localparam logic [CW-1:0] TOP = CW'(THRESHOLD - 1);

    logic [CW-1:0] dec1;
    logic [CW-1:0] dec2;

    assign dec1 = (count == '0) ? '0 : count - 1'b1;
    assign dec2 = (dec1 == '0) ? '0 : dec1 - 1'b1;

    // A leak on an incrementing lane cancels the increment, leaving the count unchanged.
    always_comb begin
        trig       = 1'b0;
        next_count = count;
        if (inc && (count == TOP)) begin
            trig       = 1'b1;
            next_count = '0;
        end else if (inc) begin
            next_count = leak ? count : count + 1'b1;
        end else begin
            next_count = leak ? dec2 : dec1;
        end
    end

endmodule

// File: rtl/accum_sched.sv
// Leaky accumulators sharing one update unit, swept one channel per cycle per step.
// Define ACCUM_SCHED_LEAK_EN to enable the periodic leak decrement and its step timer.
module accum_sched
    import accum_pkg::*;
#(
    parameter int N_CH      = 8,
    parameter int THRESHOLD = 192,
    parameter int PUSH_DOWN = 10
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    accum_sched_if.slave  bus
);
    localparam int CW = count_width(THRESHOLD);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IW-1:0] LAST_CH = IW'(N_CH - 1);

    if (N_CH < 2 || THRESHOLD < 2 || PUSH_DOWN < 1) begin : g_param_check
        $error("accum_sched: N_CH and THRESHOLD must be >= 2, PUSH_DOWN >= 1");
    end

    sched_state_e    state;
    sched_state_e    state_next;
    logic [CW-1:0]   counts [N_CH];
    logic [N_CH-1:0] inc_lat;
    logic [N_CH-1:0] trig_mask;
    logic [IW-1:0]   ch;
    logic [IW-1:0]   win_idx;
    logic            leak_lat;
    logic            step_done;
    logic            overrun;
    logic [CW-1:0]   lane_next;
    logic            lane_trig;
    logic            accept;
    logic            last_ch;
    logic            any_trig;
    logic            handshake;

    assign accept    = (state == ST_IDLE) && bus.prop_in;
    assign last_ch   = (ch == LAST_CH);
    assign any_trig  = (|trig_mask) | lane_trig;
    assign handshake = (state == ST_REPORT) && bus.win_ready_in;

    accum_lane_update #(
        .THRESHOLD (THRESHOLD),
        .CW        (CW)
    ) u_lane (
        .count      (counts[ch]),
        .inc        (inc_lat[ch]),
        .leak       (leak_lat),
        .next_count (lane_next),
        .trig       (lane_trig)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (bus.prop_in) state_next = ST_SWEEP;
            ST_SWEEP:  if (last_ch) state_next = any_trig ? ST_REPORT : ST_IDLE;
            ST_REPORT: if (bus.win_ready_in) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

`ifdef ACCUM_SCHED_LEAK_EN
    localparam int TW = (PUSH_DOWN > 1) ? $clog2(PUSH_DOWN) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(PUSH_DOWN - 1);

    logic [TW-1:0] step_timer;

    // The leak decision is frozen at acceptance so the whole sweep sees one value.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            step_timer <= '0;
            leak_lat   <= 1'b0;
        end else if (accept) begin
            leak_lat   <= (step_timer == TIMER_LAST);
            step_timer <= (step_timer == TIMER_LAST) ? '0 : step_timer + 1'b1;
        end
    end
`else
    assign leak_lat = 1'b0;
`endif

    // Strobes arriving while busy are discarded and only recorded in overrun.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < N_CH; i++) counts[i] <= '0;
            inc_lat   <= '0;
            trig_mask <= '0;
            ch        <= '0;
            step_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            step_done <= ((state == ST_SWEEP) && last_ch && !any_trig) || handshake;
            if (bus.prop_in && (state != ST_IDLE)) overrun <= 1'b1;
            if (accept) begin
                inc_lat   <= bus.inc_in;
                trig_mask <= '0;
                ch        <= '0;
            end else if (state == ST_SWEEP) begin
                counts[ch]    <= lane_next;
                trig_mask[ch] <= lane_trig;
                ch            <= last_ch ? '0 : ch + 1'b1;
            end
        end
    end

    always_comb begin
        win_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (trig_mask[i]) win_idx = IW'(i);
        end
    end

    assign bus.busy_out      = (state != ST_IDLE);
    assign bus.step_done_out = step_done;
    assign bus.win_valid_out = (state == ST_REPORT);
    assign bus.win_idx_out   = win_idx;
    assign bus.trig_mask_out = trig_mask;
    assign bus.overrun_out   = overrun;

endmodule

// File: tb/tb_accum_sched.sv
// Self-checking bench for accum_sched (N_CH=4, THRESHOLD=4, PUSH_DOWN=3) with a step-level model.
module tb_accum_sched;

    localparam int NC = 4;
    localparam int TH = 4;
    localparam int PD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    int   model_cnt [NC];
    int   model_timer;
    bit   model_overrun;

    always #5 clk = ~clk;

    accum_sched_if #(.N_CH(NC)) bus ();

    accum_sched #(
        .N_CH      (NC),
        .THRESHOLD (TH),
        .PUSH_DOWN (PD)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    // One full step of the reference: returns the set of channels that trigger.
    function automatic logic [NC-1:0] model_step(input logic [NC-1:0] inc);
        logic [NC-1:0] trig;
        bit leak;
        trig = '0;
`ifdef ACCUM_SCHED_LEAK_EN
        leak = (model_timer == PD - 1);
        model_timer = (model_timer + 1) % PD;
`else
        leak = 1'b0;
`endif
        for (int c = 0; c < NC; c++) begin
            if (inc[c] && model_cnt[c] == TH - 1) begin
                trig[c] = 1'b1;
                model_cnt[c] = 0;
            end else begin
                model_cnt[c] += inc[c] ? 1 : -1;
                if (leak) model_cnt[c] -= 1;
                if (model_cnt[c] < 0) model_cnt[c] = 0;
            end
        end
        return trig;
    endfunction

    function automatic int lowest_idx(input logic [NC-1:0] m);
        for (int c = 0; c < NC; c++) if (m[c]) return c;
        return 0;
    endfunction

    function automatic logic [2*NC-1:0] model_counts();
        logic [2*NC-1:0] r;
        for (int c = 0; c < NC; c++) r[2*c +: 2] = 2'(model_cnt[c]);
        return r;
    endfunction

    function automatic logic [2*NC-1:0] dut_counts();
        logic [2*NC-1:0] r;
        for (int c = 0; c < NC; c++) r[2*c +: 2] = dut.counts[c];
        return r;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NC; c++) model_cnt[c] = 0;
        model_timer   = 0;
        model_overrun = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.prop_in = 1'b0; bus.inc_in = '0; bus.win_ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        model_clear();
    endtask

    // Issue one strobe (optionally repeated the next cycle); lat counts edges after acceptance, -1 on timeout.
    task automatic run_sweep(input logic [NC-1:0] inc, input bit dbl, output int lat);
        bus.prop_in = 1'b1; bus.inc_in = inc;
        @(posedge clk); #1;
        bus.prop_in = dbl; bus.inc_in = NC'($urandom);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            bus.prop_in = 1'b0;
            if (bus.step_done_out || bus.win_valid_out) begin lat = k; break; end
        end
    endtask

    task automatic ack_report();
        bus.win_ready_in = 1'b1;
        @(posedge clk); #1;
        bus.win_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.prop_in = 1'b0; bus.inc_in = '0; bus.win_ready_in = 1'b0;
        #3;
        checks++; if (bus.busy_out !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", bus.busy_out); else passed++;
        checks++; if (bus.step_done_out !== 1'b0) $display("[TB] FAIL rst_done: got %b expected 0", bus.step_done_out); else passed++;
        checks++; if (bus.win_valid_out !== 1'b0) $display("[TB] FAIL rst_valid: got %b expected 0", bus.win_valid_out); else passed++;
        checks++; if (bus.trig_mask_out !== 4'b0000) $display("[TB] FAIL rst_mask: got %b expected 0000", bus.trig_mask_out); else passed++;
        checks++; if (bus.win_idx_out !== 2'd0) $display("[TB] FAIL rst_idx: got %0d expected 0", bus.win_idx_out); else passed++;
        checks++; if (bus.overrun_out !== 1'b0) $display("[TB] FAIL rst_overrun: got %b expected 0", bus.overrun_out); else passed++;
        checks++; if (dut_counts() !== 8'h00) $display("[TB] FAIL rst_counts: got %h expected 00", dut_counts()); else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++; if (bus.busy_out !== 1'b0) $display("[TB] FAIL rst_idle_after: got %b expected 0", bus.busy_out); else passed++;
        model_clear();
    endtask

    task automatic test_single_channel();
        logic [NC-1:0] em;
        int lat;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            em = model_step(4'b0001);
            run_sweep(4'b0001, 1'b0, lat);
            checks++; if (lat !== NC) $display("[TB] FAIL single_lat: step %0d got %0d expected %0d", s, lat, NC); else passed++;
            checks++; if (bus.win_valid_out !== (em != 0)) $display("[TB] FAIL single_valid: step %0d got %b expected %b", s, bus.win_valid_out, em != 0); else passed++;
            checks++; if (bus.trig_mask_out !== em) $display("[TB] FAIL single_mask: step %0d got %b expected %b", s, bus.trig_mask_out, em); else passed++;
            if (em != 0) begin
                checks++; if (int'(bus.win_idx_out) !== lowest_idx(em)) $display("[TB] FAIL single_idx: got %0d expected %0d", bus.win_idx_out, lowest_idx(em)); else passed++;
            end
            checks++; if (int'(dut.counts[0]) !== model_cnt[0]) $display("[TB] FAIL single_count0: step %0d got %0d expected %0d", s, dut.counts[0], model_cnt[0]); else passed++;
            if (bus.win_valid_out) ack_report();
            checks++; if (bus.step_done_out !== 1'b1) $display("[TB] FAIL single_done: step %0d got %b expected 1", s, bus.step_done_out); else passed++;
        end
    endtask

    task automatic test_hold();
        logic [NC-1:0] em;
        int lat;
        bit hit;
        do_reset();
        hit = 1'b0;
        for (int s = 0; s < 12 && !hit; s++) begin
            em = model_step(4'b1010);
            run_sweep(4'b1010, 1'b0, lat);
            checks++; if (lat !== NC) $display("[TB] FAIL hold_lat: step %0d got %0d expected %0d", s, lat, NC); else passed++;
            hit = (em != 0);
        end
        for (int c = 0; c < 6; c++) begin
            checks++; if (bus.win_valid_out !== 1'b1 || bus.win_idx_out !== 2'd1 || bus.trig_mask_out !== 4'b1010)
                $display("[TB] FAIL hold_stable: cycle %0d got valid=%b idx=%0d mask=%b expected 1/1/1010", c, bus.win_valid_out, bus.win_idx_out, bus.trig_mask_out);
            else passed++;
            bus.inc_in = NC'($urandom);
            if (c < 5) begin @(posedge clk); #1; end
        end
        bus.win_ready_in = 1'b1; bus.prop_in = 1'b1;
        @(posedge clk); #1;
        bus.win_ready_in = 1'b0; bus.prop_in = 1'b0;
        model_overrun = 1'b1;
        checks++; if (bus.step_done_out !== 1'b1) $display("[TB] FAIL hold_done: got %b expected 1", bus.step_done_out); else passed++;
        checks++; if (bus.overrun_out !== model_overrun) $display("[TB] FAIL hold_overrun: got %b expected %b", bus.overrun_out, model_overrun); else passed++;
        @(posedge clk); #1;
        checks++; if (bus.busy_out !== 1'b0) $display("[TB] FAIL hold_dropped: got busy=%b expected 0", bus.busy_out); else passed++;
        checks++; if (dut_counts() !== model_counts()) $display("[TB] FAIL hold_counts: got %h expected %h", dut_counts(), model_counts()); else passed++;
    endtask

    task automatic test_overrun();
        logic [NC-1:0] em;
        int lat;
        int pulses;
        do_reset();
        em = model_step(4'b0011);
        run_sweep(4'b0011, 1'b1, lat);
        model_overrun = 1'b1;
        checks++; if (lat !== NC) $display("[TB] FAIL ovr_lat: got %0d expected %0d", lat, NC); else passed++;
        checks++; if (bus.step_done_out !== 1'b1) $display("[TB] FAIL ovr_done: got %b expected 1", bus.step_done_out); else passed++;
        checks++; if (bus.overrun_out !== model_overrun) $display("[TB] FAIL ovr_flag: got %b expected %b", bus.overrun_out, model_overrun); else passed++;
        checks++; if (dut_counts() !== model_counts()) $display("[TB] FAIL ovr_counts: got %h expected %h", dut_counts(), model_counts()); else passed++;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.step_done_out || bus.busy_out) pulses++;
        end
        checks++; if (pulses !== 0) $display("[TB] FAIL ovr_extra_step: got %0d busy/done cycles expected 0", pulses); else passed++;
        em = model_step(4'b0000);
        run_sweep(4'b0000, 1'b0, lat);
        checks++; if (bus.overrun_out !== model_overrun) $display("[TB] FAIL ovr_sticky: got %b expected %b", bus.overrun_out, model_overrun); else passed++;
    endtask

    task automatic test_leak();
        logic [NC-1:0] em;
        int lat;
        int exp0;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            em = model_step(4'b0001);
            run_sweep(4'b0001, 1'b0, lat);
            if (bus.win_valid_out) ack_report();
        end
`ifdef ACCUM_SCHED_LEAK_EN
        exp0 = 2;
`else
        exp0 = 3;
`endif
        checks++; if (int'(dut.counts[0]) !== exp0) $display("[TB] FAIL leak_count0: got %0d expected %0d", dut.counts[0], exp0); else passed++;
        for (int s = 0; s < 4; s++) begin
            em = model_step(4'b0110);
            run_sweep(4'b0110, 1'b0, lat);
            checks++; if (bus.trig_mask_out !== em) $display("[TB] FAIL leak_mask: step %0d got %b expected %b", s, bus.trig_mask_out, em); else passed++;
            checks++; if (dut_counts() !== model_counts()) $display("[TB] FAIL leak_counts: step %0d got %h expected %h", s, dut_counts(), model_counts()); else passed++;
            if (bus.win_valid_out) ack_report();
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [NC-1:0] em;
        int lat;
        int pulses;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            em = model_step(4'b1111);
            run_sweep(4'b1111, 1'b0, lat);
        end
        bus.prop_in = 1'b1; bus.inc_in = 4'b1111;
        @(posedge clk); #1;
        bus.prop_in = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy_out !== 1'b0 || bus.win_valid_out !== 1'b0 || bus.step_done_out !== 1'b0)
            $display("[TB] FAIL midrst_ctrl: got busy=%b valid=%b done=%b expected 0/0/0", bus.busy_out, bus.win_valid_out, bus.step_done_out);
        else passed++;
        checks++; if (bus.trig_mask_out !== 4'b0000 || bus.overrun_out !== 1'b0)
            $display("[TB] FAIL midrst_mask: got mask=%b overrun=%b expected 0000/0", bus.trig_mask_out, bus.overrun_out);
        else passed++;
        checks++; if (dut_counts() !== 8'h00) $display("[TB] FAIL midrst_counts: got %h expected 00", dut_counts()); else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (bus.step_done_out || bus.busy_out) pulses++;
        end
        checks++; if (pulses !== 0) $display("[TB] FAIL midrst_idle: got %0d busy/done cycles expected 0", pulses); else passed++;
        em = model_step(4'b0101);
        run_sweep(4'b0101, 1'b0, lat);
        checks++; if (lat !== NC) $display("[TB] FAIL midrst_restart_lat: got %0d expected %0d", lat, NC); else passed++;
        checks++; if (dut_counts() !== model_counts()) $display("[TB] FAIL midrst_restart_counts: got %h expected %h", dut_counts(), model_counts()); else passed++;
    endtask

    task automatic test_random();
        logic [NC-1:0] em;
        logic [NC-1:0] inc;
        int lat;
        bit dbl;
        do_reset();
        for (int s = 0; s < 40; s++) begin
            inc = NC'($urandom) | NC'($urandom);
            dbl = ($urandom_range(0, 3) == 0);
            em  = model_step(inc);
            run_sweep(inc, dbl, lat);
            if (dbl) model_overrun = 1'b1;
            checks++; if (lat !== NC) $display("[TB] FAIL rand_lat: step %0d got %0d expected %0d", s, lat, NC); else passed++;
            checks++; if (bus.win_valid_out !== (em != 0)) $display("[TB] FAIL rand_valid: step %0d got %b expected %b", s, bus.win_valid_out, em != 0); else passed++;
            checks++; if (bus.trig_mask_out !== em) $display("[TB] FAIL rand_mask: step %0d got %b expected %b", s, bus.trig_mask_out, em); else passed++;
            if (em != 0) begin
                checks++; if (int'(bus.win_idx_out) !== lowest_idx(em)) $display("[TB] FAIL rand_idx: step %0d got %0d expected %0d", s, bus.win_idx_out, lowest_idx(em)); else passed++;
            end
            checks++; if (dut_counts() !== model_counts()) $display("[TB] FAIL rand_counts: step %0d got %h expected %h", s, dut_counts(), model_counts()); else passed++;
            checks++; if (bus.overrun_out !== model_overrun) $display("[TB] FAIL rand_overrun: step %0d got %b expected %b", s, bus.overrun_out, model_overrun); else passed++;
            if (bus.win_valid_out) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 ack_report();
            end
            checks++; if (bus.step_done_out !== 1'b1) $display("[TB] FAIL rand_done: step %0d got %b expected 1", s, bus.step_done_out); else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] accum_sched bench start");
        test_reset();
        test_single_channel();
        test_hold();
        test_overrun();
        test_leak();
        test_reset_mid_sweep();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
